motor_cmd_ramp: RTL and testbench
=================================

Name: motor_cmd_ramp

Overview:
- Command stage directly upstream of the dc_motor PWM driver; its psw output drives dc_motor's psw input.
- Accepts speed-level and direction requests over a valid/ready handshake.
- Ramps the 2-bit duty level one step at a time (soft start and soft stop).
- Enforces a ramp-down, zero-level, coast-dwell sequence before any direction reversal, and handles an emergency stop.

Parameters:
- STEP_TICKS, 5000000, clk cycles between successive level steps (0.1 s at 50 MHz); must be >= 1.
- DWELL_TICKS, 25000000, clk cycles held at level 0 before a direction flip (0.5 s at 50 MHz); must be >= 1.
- CNT_W, 26, timer width; must hold max(STEP_TICKS, DWELL_TICKS).

Ports:
- clk  in  1  system clock (same clock as dc_motor).
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_level  in  2  target duty level: 0 off, 1 = 25%, 2 = 50%, 3 = 75%.
- req_dir  in  1  target direction.
- estop  in  1  emergency stop, level-sensitive, sampled on clk.
- psw  out  3  {cur_dir, cur_level}, registered, drives dc_motor psw.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Reset values: psw=000, state=IDLE, tgt_level=0, tgt_dir=0, timer=0, busy=0.
  - req_ready=1 after reset release, provided estop=0.
- States: IDLE, RAMP_UP, RAMP_DOWN, DWELL, ESTOP.
- req_ready is combinational: (state==IDLE) && !estop. A transfer occurs on a clk edge with req_valid && req_ready.
- On transfer: latch tgt_level and tgt_dir, clear the timer, then choose the next state:
  - tgt_dir != cur_dir and cur_level != 0 -> RAMP_DOWN, with an internal intermediate target of 0 and a reversal pending.
  - tgt_dir != cur_dir and cur_level == 0 -> DWELL.
  - same direction, tgt_level > cur_level -> RAMP_UP.
  - same direction, tgt_level < cur_level -> RAMP_DOWN.
  - same direction and same level -> stay IDLE. This is a no-op, but the request is still consumed; busy stays 0.
- RAMP_UP and RAMP_DOWN:
  - The timer counts 0..STEP_TICKS-1.
  - On the edge where the timer equals STEP_TICKS-1: cur_level changes by +1 or -1 and the timer clears.
  - The first step lands exactly STEP_TICKS edges after the accept edge.
  - When cur_level reaches the (intermediate) target in that same update:
    - if a reversal is pending -> DWELL, timer cleared;
    - otherwise -> IDLE.
- DWELL:
  - cur_level is held at 0.
  - After DWELL_TICKS edges: cur_dir <= tgt_dir and the timer clears.
  - Then go to RAMP_UP if tgt_level > 0, else IDLE.
  - The direction flips even when tgt_level == 0.
- psw and busy are updated on the same edge as the state and level changes; there is no extra pipeline latency.
- cur_level never wraps: no increment at 3, no decrement at 0.
- estop:
  - On any edge with estop=1, from any state: cur_level <= 0, tgt_level <= 0, pending reversal cleared, timer cleared, state <= ESTOP.
  - cur_dir is held.
  - estop has priority over a simultaneous transfer; no transfer can occur anyway because req_ready is 0.
- ESTOP:
  - Stays in ESTOP while estop=1.
  - On the first edge with estop=0 -> IDLE with psw = {cur_dir, 00}.
  - The previous target is not resumed.
- req_valid while not ready: ignored. Nothing is latched and no internal state changes.
- Reset asserted mid-ramp or mid-dwell: all outputs go to reset values immediately, without waiting for a clock edge.

Test Plan (STEP_TICKS=4, DWELL_TICKS=8, 1 cycle = 1 clk edge after accept edge 0):
1. Assert rst with clk stopped -> psw=000 and busy=0 immediately; after release with estop=0, req_ready=1.
2. From 000, request level 3, dir 0 -> psw 001@4, 010@8, 011@12; busy=1 during cycles 0..11 and 0 from 12; req_ready=1 from 12.
3. From 011, request level 2, dir 1 -> psw 010@4, 001@8, 000@12; DWELL until psw 100@20; then 101@24, 110@28; IDLE@28.
4. Raise estop while ramping at psw 010 -> psw 000 next edge, direction bit held, req_ready=0, busy=1. Drop estop -> IDLE next edge with psw 000. A req_valid pulse presented during the estop period is not latched.
5. Pulse req_valid at level 1 mid-ramp -> ignored, final level unchanged. In IDLE at 010 dir 0, request 010 dir 0 -> accepted, busy stays 0, psw unchanged.
6. Assert rst in DWELL at cycle 15 of scenario 3 -> psw=000 asynchronously. After release, request level 1, dir 0 -> psw 001@4.

Source files
------------

// File: rtl/motor_cmd_ramp_if.sv
// Request channel into motor_cmd_ramp: target duty level and direction over valid/ready.
interface motor_cmd_ramp_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_level;
  logic       req_dir;

  modport master (output req_valid, output req_level, output req_dir, input req_ready);
  modport slave  (input req_valid, input req_level, input req_dir, output req_ready);
endinterface

// File: rtl/motor_cmd_ramp.sv
// Soft-start/soft-stop command stage for the dc_motor PWM driver: ramps the duty level one
// step at a time, inserts a ramp-down and coast dwell before reversing, and handles estop.
module motor_cmd_ramp #(
  parameter int unsigned STEP_TICKS  = 5000000,
  parameter int unsigned DWELL_TICKS = 25000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  motor_cmd_ramp_if.slave        req,
  input  logic                   estop,
  output logic [2:0]             psw,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] StepLast  = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_TICKS - 1);

  typedef enum logic [2:0] {StIdle, StRampUp, StRampDown, StDwell, StEstop} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cur_level_q, cur_level_d;
  logic             cur_dir_q, cur_dir_d;
  logic [1:0]       tgt_level_q, tgt_level_d;
  logic             tgt_dir_q, tgt_dir_d;
  logic [1:0]       ramp_tgt_q, ramp_tgt_d;  // level the current ramp stops at (0 on reversal)
  logic             rev_pend_q, rev_pend_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       lvl_step;

  assign req.req_ready = (state_q == StIdle) && !estop;
  assign psw           = {cur_dir_q, cur_level_q};
  assign busy          = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_level_q <= '0;
      cur_dir_q   <= 1'b0;
      tgt_level_q <= '0;
      tgt_dir_q   <= 1'b0;
      ramp_tgt_q  <= '0;
      rev_pend_q  <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_level_q <= cur_level_d;
      cur_dir_q   <= cur_dir_d;
      tgt_level_q <= tgt_level_d;
      tgt_dir_q   <= tgt_dir_d;
      ramp_tgt_q  <= ramp_tgt_d;
      rev_pend_q  <= rev_pend_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_level_d = cur_level_q;
    cur_dir_d   = cur_dir_q;
    tgt_level_d = tgt_level_q;
    tgt_dir_d   = tgt_dir_q;
    ramp_tgt_d  = ramp_tgt_q;
    rev_pend_d  = rev_pend_q;
    timer_d     = timer_q;
    lvl_step    = cur_level_q;

    if (estop) begin
      // Direction is deliberately held so the driver coasts rather than flipping.
      state_d     = StEstop;
      cur_level_d = '0;
      tgt_level_d = '0;
      ramp_tgt_d  = '0;
      rev_pend_d  = 1'b0;
      timer_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req.req_valid) begin
            tgt_level_d = req.req_level;
            tgt_dir_d   = req.req_dir;
            timer_d     = '0;
            if (req.req_dir != cur_dir_q) begin
              if (cur_level_q != 2'd0) begin
                state_d    = StRampDown;
                ramp_tgt_d = '0;
                rev_pend_d = 1'b1;
              end else begin
                state_d = StDwell;
              end
            end else if (req.req_level > cur_level_q) begin
              state_d    = StRampUp;
              ramp_tgt_d = req.req_level;
            end else if (req.req_level < cur_level_q) begin
              state_d    = StRampDown;
              ramp_tgt_d = req.req_level;
            end
          end
        end

        StRampUp, StRampDown: begin
          if (timer_q == StepLast) begin
            timer_d = '0;
            if (state_q == StRampUp) begin
              if (cur_level_q != 2'd3) lvl_step = cur_level_q + 2'd1;
            end else begin
              if (cur_level_q != 2'd0) lvl_step = cur_level_q - 2'd1;
            end
            cur_level_d = lvl_step;
            if (lvl_step == ramp_tgt_q) begin
              if (rev_pend_q) begin
                state_d    = StDwell;
                rev_pend_d = 1'b0;
              end else begin
                state_d = StIdle;
              end
            end
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end

        StDwell: begin
          cur_level_d = '0;
          if (timer_q == DwellLast) begin
            timer_d   = '0;
            cur_dir_d = tgt_dir_q;
            if (tgt_level_q != 2'd0) begin
              state_d    = StRampUp;
              ramp_tgt_d = tgt_level_q;
            end else begin
              state_d = StIdle;
            end
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end

        StEstop: state_d = StIdle;

        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Scoreboard bench for motor_cmd_ramp: stimulus pushes expected {edge, psw, busy} changes,
// a negedge monitor pops one entry on every observed change of psw/busy.
module tb_motor_cmd_ramp;
  localparam int unsigned STEP  = 4;
  localparam int unsigned DWELL = 8;

  typedef struct {
    int unsigned at;
    logic [2:0]  psw;
    logic        busy;
  } exp_t;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst    = 1'b0;
  logic       estop  = 1'b0;
  logic [2:0] psw;
  logic       busy;

  int unsigned edge_n = 0;
  int          tests  = 0;
  int          fails  = 0;
  exp_t        sb[$];
  logic [3:0]  last;

  motor_cmd_ramp_if bus ();

  motor_cmd_ramp #(
    .STEP_TICKS (STEP),
    .DWELL_TICKS(DWELL),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (bus),
    .estop(estop),
    .psw  (psw),
    .busy (busy)
  );

  always #5 if (clk_en) clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every change of {psw, busy} must match the next expected entry, at its edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last = {psw, busy};
    end else if ({psw, busy} !== last) begin
      last  = {psw, busy};
      tests = tests + 1;
      if (sb.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_change: got psw=%b busy=%b at edge %0d, required no change",
                 psw, busy, edge_n);
      end else begin
        e = sb.pop_front();
        if (psw !== e.psw || busy !== e.busy || edge_n != e.at) begin
          fails = fails + 1;
          $display("FAIL sb_change: got psw=%b busy=%b at edge %0d, required psw=%b busy=%b at edge %0d",
                   psw, busy, edge_n, e.psw, e.busy, e.at);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests = tests + 1;
    if (act !== req) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input int unsigned at, input logic [2:0] p, input logic b);
    exp_t e;
    e.at = at; e.psw = p; e.busy = b;
    sb.push_back(e);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] lvl, input logic dir, output int unsigned acc);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_level = lvl;
    bus.req_dir   = dir;
    chk("accept_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    acc           = edge_n;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int unsigned a;
    bus.req_valid = 1'b0;
    bus.req_level = 2'd0;
    bus.req_dir   = 1'b0;

    // Reset with the clock stopped must act immediately.
    #3 rst = 1'b1;
    #1;
    chk("rst_psw", 32'(psw), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    // Soft start 000 -> 011.
    accept(2'd3, 1'b0, a);
    push(a, 3'b000, 1'b1);
    push(a + 4, 3'b001, 1'b1);
    push(a + 8, 3'b010, 1'b1);
    push(a + 12, 3'b011, 1'b0);
    wait_edges(12);
    chk("ramp_up_ready", 32'(bus.req_ready), 32'd1);

    // Reversal: ramp down to 0, dwell, flip, ramp up to 2.
    accept(2'd2, 1'b1, a);
    push(a, 3'b011, 1'b1);
    push(a + 4, 3'b010, 1'b1);
    push(a + 8, 3'b001, 1'b1);
    push(a + 12, 3'b000, 1'b1);
    push(a + 20, 3'b100, 1'b1);
    push(a + 24, 3'b101, 1'b1);
    push(a + 28, 3'b110, 0);
    wait_edges(28);

    // Estop mid-ramp: level drops, direction held, requests ignored.
    accept(2'd3, 1'b1, a);
    push(a, 3'b110, 1'b1);
    wait_edges(2);
    @(negedge clk);
    estop = 1'b1;
    #1;
    chk("estop_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_level = 2'd1;
    bus.req_dir   = 1'b0;
    @(posedge clk);
    #1;
    push(edge_n, 3'b100, 1'b1);
    wait_edges(3);
    chk("estop_busy", 32'(busy), 32'd1);
    chk("estop_ready_hold", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    estop         = 1'b0;
    @(posedge clk);
    #1;
    push(edge_n, 3'b100, 1'b0);
    wait_edges(10);
    chk("estop_no_latch", 32'(psw), 32'b100);

    // Request while busy is ignored; same-level request is a silent no-op.
    accept(2'd2, 1'b1, a);
    push(a, 3'b100, 1'b1);
    push(a + 4, 3'b101, 1'b1);
    push(a + 8, 3'b110, 1'b0);
    wait_edges(5);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_level = 2'd1;
    bus.req_dir   = 1'b1;
    #1;
    chk("busy_not_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_edges(6);
    accept(2'd2, 1'b1, a);
    wait_edges(4);
    chk("noop_busy", 32'(busy), 32'd0);
    chk("noop_psw", 32'(psw), 32'b110);

    // Asynchronous reset in the middle of the dwell.
    accept(2'd0, 1'b0, a);
    push(a, 3'b110, 1'b1);
    push(a + 4, 3'b101, 1'b1);
    push(a + 8, 3'b100, 1'b1);
    wait_edges(15);
    rst = 1'b1;
    #1;
    chk("dwell_rst_psw", 32'(psw), 32'd0);
    chk("dwell_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    accept(2'd1, 1'b0, a);
    push(a, 3'b000, 1'b1);
    push(a + 4, 3'b001, 1'b0);
    wait_edges(4);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
